// File: rtl/qsfp_i2c_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C command engine between NUM_REQ sequencers.
// Each request is captured, then issued as a single command pulse, and its completion is routed back to the owner.
//
// state   | meaning
// ST_IDLE | no transaction in flight; pick the next pending requester
// ST_WAIT | command issued; waiting for engine completion or the timeout
// ST_DONE | one-cycle gap; IO fields and grant return to zero
module qsfp_i2c_arbiter #(
  parameter int          NUM_REQ        = 5,
  parameter int          TIMEOUT_CYCLES = 50000000,
  parameter logic [7:0]  TIMEOUT_RDATA  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     req_pulse,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_id,
  input  logic [8*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_cmplt,
  output logic [NUM_REQ-1:0]     req_timeout,
  output logic [7:0]             req_rdata,
  output logic [NUM_REQ-1:0]     req_overrun,
  output logic                   IO_CONTROL_PULSE,
  output logic                   IO_CONTROL_RW,
  output logic [7:0]             IO_CONTROL_ID,
  output logic [7:0]             IO_ADDR_ADDR,
  output logic [7:0]             IO_WDATA_WDATA,
  input  logic [7:0]             IO_RDATA_RDATA,
  input  logic                   IO_CONTROL_CMPLT,
  output logic [7:0]             dbg_cstate,
  output logic [NUM_REQ-1:0]     dbg_grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [7:0] {
    ST_IDLE = 8'h00,
    ST_WAIT = 8'h01,
    ST_DONE = 8'h02
  } state_t;

  state_t                 state_q;
  logic [NUM_REQ-1:0]     pending_q, pending_d;
  logic [NUM_REQ-1:0]     overrun_q, overrun_d;
  logic [NUM_REQ-1:0]     slot_rw_q, slot_rw_d;
  logic [8*NUM_REQ-1:0]   slot_id_q, slot_id_d;
  logic [8*NUM_REQ-1:0]   slot_addr_q, slot_addr_d;
  logic [8*NUM_REQ-1:0]   slot_wdata_q, slot_wdata_d;
  logic [31:0]            timer_q;
  logic [PW-1:0]          ptr_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [NUM_REQ-1:0]     cmplt_q, timeout_q;
  logic [7:0]             rdata_q;
  logic                   pulse_q, rw_q;
  logic [7:0]             id_q, addr_q, wdata_q;

  logic                   fin_ok, fin_to;
  logic [NUM_REQ-1:0]     clr;
  logic                   win_vld;
  logic [PW-1:0]          win_idx, cand;
  logic                   win_rw;
  logic [7:0]             win_id, win_addr, win_wdata;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NUM_REQ;
    return PW'(s);
  endfunction

  // A completion that coincides with the timeout is treated as a normal completion.
  always_comb begin
    fin_ok = (state_q == ST_WAIT) && IO_CONTROL_CMPLT;
    fin_to = (state_q == ST_WAIT) && !IO_CONTROL_CMPLT &&
             (timer_q == 32'(TIMEOUT_CYCLES - 1));
    clr    = (fin_ok || fin_to) ? grant_q : '0;
  end

  // Walk from ptr+NUM_REQ down to ptr+1 so the nearest pending requester is assigned last.
  always_comb begin
    win_vld   = 1'b0;
    win_idx   = '0;
    cand      = '0;
    win_rw    = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = rr_idx(ptr_q, k);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (PW'(i) == cand && pending_q[i]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == win_idx) begin
        win_rw    = slot_rw_q[i];
        win_id    = slot_id_q[8*i +: 8];
        win_addr  = slot_addr_q[8*i +: 8];
        win_wdata = slot_wdata_q[8*i +: 8];
      end
    end
  end

  // A pulse landing on the cycle its pending flag is cleared is accepted (set wins).
  always_comb begin
    pending_d    = pending_q & ~clr;
    overrun_d    = overrun_q;
    slot_rw_d    = slot_rw_q;
    slot_id_d    = slot_id_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_pulse[i]) begin
        if (pending_q[i] && !clr[i]) begin
          overrun_d[i] = 1'b1;
        end else begin
          pending_d[i]             = 1'b1;
          slot_rw_d[i]             = req_rw[i];
          slot_id_d[8*i +: 8]      = req_id[8*i +: 8];
          slot_addr_d[8*i +: 8]    = req_addr[8*i +: 8];
          slot_wdata_d[8*i +: 8]   = req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q    <= '0;
      overrun_q    <= '0;
      slot_rw_q    <= '0;
      slot_id_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
    end else begin
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      slot_rw_q    <= slot_rw_d;
      slot_id_q    <= slot_id_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      ptr_q     <= PW'(NUM_REQ - 1);
      grant_q   <= '0;
      cmplt_q   <= '0;
      timeout_q <= '0;
      rdata_q   <= '0;
      pulse_q   <= 1'b0;
      rw_q      <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      pulse_q   <= 1'b0;
      cmplt_q   <= '0;
      timeout_q <= '0;
      rdata_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            pulse_q <= 1'b1;
            rw_q    <= win_rw;
            id_q    <= win_id;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            grant_q <= NUM_REQ'(1) << win_idx;
            ptr_q   <= win_idx;
            timer_q <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fin_ok) begin
            cmplt_q <= grant_q;
            rdata_q <= IO_RDATA_RDATA;
            state_q <= ST_DONE;
          end else if (fin_to) begin
            cmplt_q   <= grant_q;
            timeout_q <= grant_q;
            rdata_q   <= TIMEOUT_RDATA;
            state_q   <= ST_DONE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        ST_DONE: begin
          rw_q    <= 1'b0;
          id_q    <= '0;
          addr_q  <= '0;
          wdata_q <= '0;
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_cmplt        = cmplt_q;
  assign req_timeout      = timeout_q;
  assign req_rdata        = rdata_q;
  assign req_overrun      = overrun_q;
  assign IO_CONTROL_PULSE = pulse_q;
  assign IO_CONTROL_RW    = rw_q;
  assign IO_CONTROL_ID    = id_q;
  assign IO_ADDR_ADDR     = addr_q;
  assign IO_WDATA_WDATA   = wdata_q;
  assign dbg_cstate       = state_q;
  assign dbg_grant        = grant_q;

endmodule

// File: tb/tb_qsfp_i2c_arbiter.sv
// Directed bench for qsfp_i2c_arbiter; a negedge monitor checks issues and completions against
// scoreboard queues filled as stimulus is driven.
module tb_qsfp_i2c_arbiter;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req_pulse, req_rw;
  logic [8*N-1:0] req_id, req_addr, req_wdata;
  logic [N-1:0]   req_cmplt, req_timeout, req_overrun, dbg_grant;
  logic [7:0]     req_rdata, dbg_cstate;
  logic           IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_CMPLT;
  logic [7:0]     IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA, IO_RDATA_RDATA;

  qsfp_i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(100), .TIMEOUT_RDATA(8'hFF)) dut (
    .clk(clk), .rstn(rstn),
    .req_pulse(req_pulse), .req_rw(req_rw), .req_id(req_id), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_cmplt(req_cmplt), .req_timeout(req_timeout),
    .req_rdata(req_rdata), .req_overrun(req_overrun),
    .IO_CONTROL_PULSE(IO_CONTROL_PULSE), .IO_CONTROL_RW(IO_CONTROL_RW),
    .IO_CONTROL_ID(IO_CONTROL_ID), .IO_ADDR_ADDR(IO_ADDR_ADDR),
    .IO_WDATA_WDATA(IO_WDATA_WDATA), .IO_RDATA_RDATA(IO_RDATA_RDATA),
    .IO_CONTROL_CMPLT(IO_CONTROL_CMPLT), .dbg_cstate(dbg_cstate), .dbg_grant(dbg_grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int iss_cnt = 0, cpl_cnt = 0, last_iss = 0, last_cpl = 0;
  int t_pulse = 0, t_c = 0, p = 0, n0 = 0, c0 = 0;
  logic [63:0] iss_q[$];
  logic [63:0] cpl_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ei(input int i, input logic rw, input logic [7:0] id,
                                     input logic [7:0] a, input logic [7:0] w);
    logic [N-1:0] g;
    g = N'(1) << i;
    return {34'd0, g, rw, id, a, w};
  endfunction

  function automatic logic [63:0] ec(input int i, input logic to, input logic [7:0] rd);
    logic [N-1:0] g;
    g = N'(1) << i;
    return {46'd0, g, (to ? g : N'(0)), rd};
  endfunction

  function automatic logic [63:0] all_out();
    return {2'd0, req_cmplt, req_timeout, req_rdata, req_overrun, IO_CONTROL_PULSE,
            IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA, dbg_cstate, dbg_grant};
  endfunction

  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (rstn === 1'b1) begin
      if (IO_CONTROL_PULSE) begin
        iss_cnt++;
        last_iss = cyc;
        if (iss_q.size() > 0) begin
          e = iss_q.pop_front();
          chk("issue", {34'd0, dbg_grant, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR,
                        IO_WDATA_WDATA}, e);
        end else chk("unexpected_issue", 64'(IO_CONTROL_PULSE), 64'd0);
      end
      if (|req_cmplt || |req_timeout) begin
        cpl_cnt++;
        last_cpl = cyc;
        if (cpl_q.size() > 0) begin
          e = cpl_q.pop_front();
          chk("cmplt", {46'd0, req_cmplt, req_timeout, req_rdata}, e);
        end else chk("unexpected_cmplt", 64'(req_cmplt), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic set_req(input int i, input logic rw, input logic [7:0] id,
                         input logic [7:0] a, input logic [7:0] w, input bit push);
    req_pulse[i]       = 1'b1;
    req_rw[i]          = rw;
    req_id[8*i +: 8]   = id;
    req_addr[8*i +: 8] = a;
    req_wdata[8*i +: 8] = w;
    if (push) iss_q.push_back(ei(i, rw, id, a, w));
  endtask

  task automatic fire();
    t_pulse = cyc;
    step();
    req_pulse = '0;
  endtask

  task automatic complete(input logic [7:0] rd);
    IO_CONTROL_CMPLT = 1'b1;
    IO_RDATA_RDATA   = rd;
    t_c = cyc;
    step();
    IO_CONTROL_CMPLT = 1'b0;
    IO_RDATA_RDATA   = 8'h00;
  endtask

  task automatic wait_iss(input int n);
    int k = 0;
    while (iss_cnt <= n && k < 400) begin sample(); k++; end
    chk("issue_wait", 64'(iss_cnt > n), 64'd1);
  endtask

  task automatic wait_cpl(input int n);
    int k = 0;
    while (cpl_cnt <= n && k < 400) begin sample(); k++; end
    chk("cmplt_wait", 64'(cpl_cnt > n), 64'd1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    iss_q.delete();
    cpl_q.delete();
    repeat (2) step();
    rstn = 1'b1;
    step();
  endtask

  initial begin
    rstn = 1'b0;
    req_pulse = '0; req_rw = '0; req_id = '0; req_addr = '0; req_wdata = '0;
    IO_CONTROL_CMPLT = 1'b0; IO_RDATA_RDATA = 8'h00;
    repeat (2) step();
    chk("reset_outputs", all_out(), 64'd0);
    rstn = 1'b1;
    repeat (3) step();

    // single write from requester 1
    n0 = iss_cnt;
    set_req(1, 1'b0, 8'hA0, 8'h10, 8'h55, 1);
    fire();
    wait_iss(n0);
    chk("issue_latency", 64'(last_iss), 64'(t_pulse + 2));
    sample();
    chk("pulse_one_cycle", 64'(IO_CONTROL_PULSE), 64'd0);
    step();
    wait_to(t_pulse + 30);
    chk("io_hold", {39'd0, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA},
        {39'd0, 1'b0, 8'hA0, 8'h10, 8'h55});
    cpl_q.push_back(ec(1, 1'b0, 8'h00));
    complete(8'h00);
    sample();
    chk("cmplt_latency", 64'(last_cpl), 64'(t_c + 1));
    chk("state_done", 64'(dbg_cstate), 64'h02);
    sample();
    chk("done_clears_io", {35'd0, IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR, IO_WDATA_WDATA,
                           dbg_grant}, 64'd0);

    // read from requester 3
    step();
    n0 = iss_cnt;
    set_req(3, 1'b1, 8'h51, 8'h22, 8'h00, 1);
    fire();
    wait_iss(n0);
    repeat (3) step();
    cpl_q.push_back(ec(3, 1'b0, 8'h3C));
    complete(8'h3C);
    sample();
    chk("read_rdata", 64'(req_rdata), 64'h3C);

    // fairness after reset: all five at once, then 0 and 4 together
    do_reset();
    n0 = iss_cnt;
    for (int i = 0; i < N; i++)
      set_req(i, 1'(i), 8'(8'h60 + i), 8'(8'h20 + i), 8'(8'h90 + i), 1);
    fire();
    for (int j = 0; j < N; j++) begin
      wait_iss(n0 + j);
      if (j > 0) chk("b2b_spacing", 64'(last_iss), 64'(t_c + 3));
      repeat (2) step();
      cpl_q.push_back(ec(j, 1'b0, 8'(8'h10 + j)));
      complete(8'(8'h10 + j));
    end
    repeat (3) step();
    n0 = iss_cnt;
    set_req(0, 1'b0, 8'hB0, 8'h01, 8'h02, 1);
    set_req(4, 1'b1, 8'hB4, 8'h03, 8'h04, 1);
    fire();
    for (int j = 0; j < 2; j++) begin
      wait_iss(n0 + j);
      repeat (2) step();
      cpl_q.push_back(ec(j == 0 ? 0 : 4, 1'b0, 8'hC0));
      complete(8'hC0);
    end

    // timeout on requester 1; requester 2 then completes on the timeout cycle
    repeat (3) step();
    n0 = iss_cnt;
    c0 = cpl_cnt;
    set_req(1, 1'b0, 8'hD1, 8'h31, 8'h41, 1);
    set_req(2, 1'b1, 8'hD2, 8'h32, 8'h42, 1);
    fire();
    cpl_q.push_back(ec(1, 1'b1, 8'hFF));
    wait_iss(n0);
    p = last_iss;
    wait_cpl(c0);
    chk("timeout_latency", 64'(last_cpl), 64'(p + 100));
    wait_iss(n0 + 1);
    chk("post_timeout_issue", 64'(last_iss), 64'(last_cpl + 2));
    p = last_iss;
    step();
    wait_to(p + 99);
    cpl_q.push_back(ec(2, 1'b0, 8'hA5));
    complete(8'hA5);
    sample();
    chk("cmplt_beats_timeout", {56'd0, 3'd0, req_timeout}, 64'd0);
    chk("cmplt_at_timeout_lat", 64'(last_cpl), 64'(p + 100));

    // overrun on requester 2, then a stray completion while idle
    repeat (3) step();
    n0 = iss_cnt;
    set_req(2, 1'b0, 8'hE2, 8'h52, 8'h62, 1);
    fire();
    wait_iss(n0);
    p = last_iss;
    step();
    set_req(2, 1'b1, 8'hEE, 8'hEE, 8'hEE, 0);
    fire();
    set_req(2, 1'b1, 8'hEF, 8'hEF, 8'hEF, 0);
    fire();
    sample();
    chk("overrun_set", 64'(req_overrun), 64'h04);
    step();
    wait_to(p + 10);
    cpl_q.push_back(ec(2, 1'b0, 8'h00));
    complete(8'h00);
    repeat (15) step();
    chk("overrun_single_issue", 64'(iss_cnt), 64'(n0 + 1));
    chk("idle_before_stray", 64'(dbg_cstate), 64'h00);
    c0 = cpl_cnt;
    complete(8'h77);
    repeat (5) step();
    chk("stray_cmplt_ignored", 64'(cpl_cnt), 64'(c0));

    // new pulse on the completion cycle is accepted without overrun
    n0 = iss_cnt;
    set_req(3, 1'b0, 8'hF3, 8'h13, 8'h23, 1);
    fire();
    wait_iss(n0);
    p = last_iss;
    step();
    wait_to(p + 5);
    cpl_q.push_back(ec(3, 1'b0, 8'h11));
    set_req(3, 1'b1, 8'h33, 8'h44, 8'h00, 1);
    complete(8'h11);
    req_pulse = '0;
    sample();
    chk("set_wins_no_overrun", 64'(req_overrun), 64'h04);
    wait_iss(n0 + 1);
    chk("set_wins_issue_lat", 64'(last_iss), 64'(t_c + 3));
    repeat (2) step();
    cpl_q.push_back(ec(3, 1'b0, 8'h22));
    complete(8'h22);

    // asynchronous reset in the middle of a wait
    repeat (3) step();
    n0 = iss_cnt;
    set_req(4, 1'b0, 8'h44, 8'h45, 8'h46, 1);
    fire();
    wait_iss(n0);
    repeat (2) step();
    #3;
    rstn = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), 64'd0);
    iss_q.delete();
    cpl_q.delete();
    repeat (2) step();
    rstn = 1'b1;
    c0 = cpl_cnt;
    repeat (5) step();
    chk("no_cmplt_after_reset", 64'(cpl_cnt), 64'(c0));
    n0 = iss_cnt;
    set_req(0, 1'b1, 8'h0A, 8'h0B, 8'h0C, 1);
    set_req(4, 1'b0, 8'h4A, 8'h4B, 8'h4C, 1);
    fire();
    for (int j = 0; j < 2; j++) begin
      wait_iss(n0 + j);
      repeat (2) step();
      cpl_q.push_back(ec(j == 0 ? 0 : 4, 1'b0, 8'h5A));
      complete(8'h5A);
    end
    repeat (5) step();
    chk("scoreboard_drained", 64'(iss_q.size() + cpl_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/qsfp_i2c_arbiter.md
Name: qsfp_i2c_arbiter

Overview:
- Shares the single byte-level I2C command interface (IO_CONTROL_*) between NUM_REQ sequencers: the power sequencer and the QSFP sideband sequencers.
- Replaces wired-OR bus merging with registered, round-robin granted, one-transaction-at-a-time access.
- Captures single-cycle requests, issues each request as one command pulse and routes completion and read data back to the owner.
- Adds a completion timeout so a hung I2C transaction cannot stall the system.

Parameters:
- NUM_REQ, 5, number of requesters (index 0 = power sequencer, 1..4 = QSFP0..3).
- TIMEOUT_CYCLES, 50000000, maximum cycles in WAIT before a forced completion (1 s at 50 MHz).
- TIMEOUT_RDATA, 8'hFF, read data returned on timeout.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req_pulse  in  NUM_REQ  one-cycle command request, one bit per requester.
- req_rw  in  NUM_REQ  1 = read, 0 = write, per requester.
- req_id  in  8*NUM_REQ  I2C device ID, per requester.
- req_addr  in  8*NUM_REQ  register address, per requester.
- req_wdata  in  8*NUM_REQ  write data, per requester.
- req_cmplt  out  NUM_REQ  one-cycle completion strobe to the owner.
- req_timeout  out  NUM_REQ  qualifies req_cmplt; high in the same cycle when the command timed out.
- req_rdata  out  8  read data, broadcast; valid only in the cycle req_cmplt is high.
- req_overrun  out  NUM_REQ  sticky; requester pulsed while its own request was still pending.
- IO_CONTROL_PULSE  out  1  command start to the I2C engine.
- IO_CONTROL_RW  out  1  command direction.
- IO_CONTROL_ID  out  8  device ID.
- IO_ADDR_ADDR  out  8  register address.
- IO_WDATA_WDATA  out  8  write data.
- IO_RDATA_RDATA  in  8  read data from the I2C engine.
- IO_CONTROL_CMPLT  in  1  command done strobe from the I2C engine.
- dbg_cstate  out  8  current state of the arbiter.
- dbg_grant  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.

Behaviour:
- Reset (rstn=0, asynchronous):
  - All outputs are 0; dbg_cstate = ST_IDLE (8'h00).
  - Pending flags, overrun bits and timer are cleared.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins the first arbitration.
- Capture: req_pulse[i]=1 with pending[i]=0 sets pending[i] on the next edge and latches that requester's rw/id/addr/wdata into its slot.
  - If pending[i]=1, the pulse is dropped, the slot is unchanged and req_overrun[i] is set.
  - req_overrun[i] clears only on reset.
- States:
  - ST_IDLE (00): if any pending, pick the winner by round-robin (search pointer+1 upward, wrapping modulo NUM_REQ).
    - Load the winner's slot into the IO_* registers.
    - Assert IO_CONTROL_PULSE for exactly one cycle; set dbg_grant; update the pointer to the winner; go to ST_WAIT.
  - ST_WAIT (01): timer increments each cycle.
    - On IO_CONTROL_CMPLT=1: req_cmplt[g]=1 and req_rdata=IO_RDATA_RDATA on the next cycle; clear pending[g]; go to ST_DONE.
    - If the timer reaches TIMEOUT_CYCLES-1 without completion: req_cmplt[g]=1, req_timeout[g]=1, req_rdata=TIMEOUT_RDATA; clear pending[g]; go to ST_DONE.
  - ST_DONE (02): one-cycle gap. Drive IO_CONTROL_ID/ADDR/WDATA/RW back to 0 and dbg_grant to 0; go to ST_IDLE.
- Latency:
  - Pulse at cycle t with the arbiter idle gives IO_CONTROL_PULSE at t+2.
  - CMPLT at cycle c gives req_cmplt at c+1.
  - Minimum back-to-back issue spacing is CMPLT + 3 cycles.
- IO_* fields are held stable from the pulse cycle until ST_DONE.
- Boundary rules:
  - IO_CONTROL_CMPLT in ST_IDLE or ST_DONE is ignored.
  - CMPLT arriving in the same cycle the timeout fires counts as a normal completion (req_timeout=0).
  - A new req_pulse[g] in the same cycle pending[g] is cleared by completion is accepted: set wins, no overrun.
  - Simultaneous pulses from multiple requesters are all captured; they are served in round-robin order, one per transaction.
  - Timer is 32 bit, cleared on entry to ST_WAIT.
  - Reset mid-transaction aborts immediately: no req_cmplt is issued and all pending requests are lost.

Test Plan:
- Single write: req 1 pulses rw=0, id=8'hA0, addr=8'h10, wdata=8'h55 at t=10 -> IO_CONTROL_PULSE at t=12 with those fields; CMPLT at t=40 -> req_cmplt=5'b00010 at t=41, req_timeout=0.
- Read data return: req 3 reads, engine drives IO_RDATA_RDATA=8'h3C with CMPLT -> req_rdata=8'h3C in the req_cmplt[3] cycle.
- Fairness: all 5 requesters pulse in the same cycle after reset -> grants in order 0,1,2,3,4. Then 0 and 4 pulse together -> 0 is served before 4 (pointer was 4).
- Timeout: TIMEOUT_CYCLES=100, no CMPLT -> req_cmplt and req_timeout for the owner exactly 100 cycles after the issue pulse, req_rdata=8'hFF; the next pending request then issues.
- Overrun: req 2 pulses twice while its first request waits -> req_overrun[2]=1; only the first request issues; a stray CMPLT while idle produces no req_cmplt.
- Reset mid-WAIT: drop rstn during ST_WAIT -> all outputs 0 asynchronously; after release, no completion is reported and the next request is served by requester 0 first.
